// File: rtl/jal_word_encoder.sv
// Encodes a signed byte offset plus rd into a RISC-V JAL word. Unencodable offsets become a NOP with
// out_err set. The result sits in a main/skid buffer pair so in_ready is a flop and throughput stays at one word per cycle.
module jal_word_encoder #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_offset,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [ERR_W-1:0] err_count
);

  // Handshake: a side transfers on a rising clk edge where its valid and ready are both high.
  // Once out_valid rises it stays high, and out_word/out_err stay unchanged, until the consumer takes the word.

  logic [20:0] imm;
  logic        offset_ok;
  logic [31:0] enc_word;

  always_comb begin
    imm       = in_offset[20:0];
    // The offset must fit a 21-bit signed field and be halfword aligned.
    offset_ok = (in_offset[31:20] == {12{in_offset[20]}}) && !in_offset[0];
    enc_word  = offset_ok ? {imm[20], imm[10:1], imm[11], imm[19:12], in_rd, 7'b1101111}
                          : 32'h0000_0013;
  end

  logic        main_valid, skid_valid, ready_q;
  logic [31:0] main_word, skid_word;
  logic        main_err, skid_err;
  logic        main_valid_d, skid_valid_d;
  logic [31:0] main_word_d, skid_word_d;
  logic        main_err_d, skid_err_d;
  logic        in_fire, out_fire;

  assign in_fire  = in_valid && ready_q;
  assign out_fire = main_valid && out_ready;

  always_comb begin
    main_valid_d = main_valid;
    main_word_d  = main_word;
    main_err_d   = main_err;
    skid_valid_d = skid_valid;
    skid_word_d  = skid_word;
    skid_err_d   = skid_err;
    if (out_fire || !main_valid) begin
      // Main is free this cycle; the skid word is older than any new input, so it goes first.
      if (skid_valid) begin
        main_valid_d = 1'b1;
        main_word_d  = skid_word;
        main_err_d   = skid_err;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_word_d  = enc_word;
        main_err_d   = !offset_ok;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_word_d  = enc_word;
      skid_err_d   = !offset_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_word  <= 32'h0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_word  <= 32'h0;
      skid_err   <= 1'b0;
      ready_q    <= 1'b1;
      enc_count  <= '0;
      err_count  <= '0;
    end else begin
      main_valid <= main_valid_d;
      main_word  <= main_word_d;
      main_err   <= main_err_d;
      skid_valid <= skid_valid_d;
      skid_word  <= skid_word_d;
      skid_err   <= skid_err_d;
      ready_q    <= !skid_valid_d;
      if (in_fire) begin
        enc_count <= enc_count + CNT_W'(1);
        if (!offset_ok && (err_count != {ERR_W{1'b1}}))
          err_count <= err_count + ERR_W'(1);
      end
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_word  = main_word;
  assign out_err   = main_err;

endmodule

// File: tb/tb_jal_word_encoder.sv
// Bench for jal_word_encoder: a queue model with occupancy-based flow control is checked on every negedge,
// and directed scenarios also compare against hand-computed instruction words.
module tb_jal_word_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_offset;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  jal_word_encoder #(.CNT_W(16), .ERR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_offset (in_offset),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: bit 32 is the error flag, bits 31:0 are the instruction word.
  function automatic logic [32:0] ref_enc(input logic [31:0] off, input logic [4:0] rd);
    int          s;
    logic [31:0] u;
    logic [31:0] w;
    s = signed'(off);
    if (s < -1048576 || s > 1048575 || (s % 2) != 0) return {1'b1, 32'h0000_0013};
    u = off & 32'h001F_FFFF;
    w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 32'h1) << 20)
      | (((u >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'h6F;
    return {1'b0, w};
  endfunction

  // Scoreboard
  logic [32:0] exp_q[$];
  logic [31:0] got_q[$];
  logic        got_err[$];
  int          got_cyc[$];
  int          m_enc = 0;
  int          m_err = 0;
  bit          known = 1'b0;
  bit          in_f, out_f;
  logic [32:0] e;

  always @(negedge clk) begin
    if (known) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        chk("out_word", out_word, exp_q[0][31:0]);
        chk("out_err", 32'(out_err), 32'(exp_q[0][32]));
      end
      chk("enc_count", 32'(enc_count), 32'(m_enc & 32'hFFFF));
      chk("err_count", 32'(err_count), 32'(m_err));
    end
    if (!rst_n) begin
      exp_q.delete();
      m_enc = 0;
      m_err = 0;
      known = 1'b1;
    end else if (known) begin
      in_f  = in_valid && (exp_q.size() < 2);
      out_f = (exp_q.size() > 0) && out_ready;
      if (out_f) begin
        got_q.push_back(out_word);
        got_err.push_back(out_err);
        got_cyc.push_back(cyc);
        void'(exp_q.pop_front());
      end
      if (in_f) begin
        e = ref_enc(in_offset, in_rd);
        exp_q.push_back(e);
        m_enc++;
        if (e[32] && m_err < 255) m_err++;
      end
    end
  end

  // Driver tasks
  bit rand_rdy = 1'b0;

  task automatic wait_accept();
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      n++;
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] off, input logic [4:0] rd);
    in_valid  = 1'b1;
    in_offset = off;
    in_rd     = rd;
    wait_accept();
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (got_q.size() < n && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("drain_count", 32'(got_q.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_got();
    got_q.delete();
    got_err.delete();
    got_cyc.delete();
  endtask

  function automatic logic [31:0] rand_valid();
    logic [20:0] r;
    r    = 21'($urandom);
    r[0] = 1'b0;
    return {{11{r[20]}}, r};
  endfunction

  function automatic logic [31:0] rand_invalid();
    logic [31:0] r;
    r = $urandom;
    if (!ref_enc(r, 5'd0)[32]) r[0] = 1'b1;
    return r;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_offset = 32'h0;
    in_rd     = 5'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_word", out_word, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_enc", 32'(enc_count), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;

    // Single word, one-cycle latency
    send(32'h0000_0800, 5'd1);
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_word", out_word, 32'h0010_00EF);
    chk("t1_err", 32'(out_err), 32'd0);
    chk("t1_enc", 32'(enc_count), 32'd1);
    @(posedge clk);
    #1;

    // Boundary offsets back-to-back
    clear_got();
    send(32'hFFFF_FFFC, 5'd0);
    send(32'h000F_FFFE, 5'd0);
    send(32'hFFF0_0000, 5'd0);
    drain(3);
    if (got_q.size() == 3) begin
      chk("bnd_w0", got_q[0], 32'hFFDF_F06F);
      chk("bnd_w1", got_q[1], 32'h7FFF_F06F);
      chk("bnd_w2", got_q[2], 32'h8000_006F);
      chk("bnd_rate01", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
      chk("bnd_rate12", 32'(got_cyc[2] - got_cyc[1]), 32'd1);
    end

    // Invalid offsets
    reset_dut();
    clear_got();
    send(32'h0010_0000, 5'd5);
    send(32'h0000_0003, 5'd7);
    drain(2);
    if (got_q.size() == 2) begin
      chk("inv_w0", got_q[0], 32'h0000_0013);
      chk("inv_e0", 32'(got_err[0]), 32'd1);
      chk("inv_w1", got_q[1], 32'h0000_0013);
      chk("inv_e1", 32'(got_err[1]), 32'd1);
    end
    @(negedge clk);
    chk("inv_enc", 32'(enc_count), 32'd2);
    chk("inv_err", 32'(err_count), 32'd2);
    @(posedge clk);
    #1;

    // Backpressure: two accepted, third waits for in_ready
    reset_dut();
    clear_got();
    out_ready = 1'b0;
    send(32'h0000_0800, 5'd1);
    send(32'hFFFF_FFFC, 5'd0);
    @(negedge clk);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    chk("bp_hold_word", out_word, 32'h0010_00EF);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_offset = 32'h000F_FFFE;
    in_rd     = 5'd0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(in_ready), 32'd0);
      chk("bp_stall_valid", 32'(out_valid), 32'd1);
      chk("bp_stall_word", out_word, 32'h0010_00EF);
    end
    chk("bp_none_out", 32'(got_q.size()), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    drain(3);
    if (got_q.size() == 3) begin
      chk("bp_w0", got_q[0], 32'h0010_00EF);
      chk("bp_w1", got_q[1], 32'hFFDF_F06F);
      chk("bp_w2", got_q[2], 32'h7FFF_F06F);
    end

    // Reset mid-stream drops buffered words
    reset_dut();
    out_ready = 1'b0;
    send(32'h0000_0100, 5'd3);
    send(32'h0000_0200, 5'd4);
    reset_dut();
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_enc", 32'(enc_count), 32'd0);
    chk("mid_err", 32'(err_count), 32'd0);
    clear_got();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_no_replay", 32'(got_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Error saturation under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) send(rand_invalid(), 5'($urandom));
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("sat_err", 32'(err_count), 32'd255);
    chk("sat_enc", 32'(enc_count), 32'd300);
    @(posedge clk);
    #1;

    // Counter wrap at 65537 accepted words
    for (int i = 300; i < 65537; i++) begin
      if ($urandom_range(0, 15) == 0) send(rand_invalid(), 5'($urandom));
      else send(rand_valid(), 5'($urandom));
    end
    @(negedge clk);
    chk("wrap_enc", 32'(enc_count), 32'd1);
    chk("wrap_err", 32'(err_count), 32'd255);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
